bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum consecutive accepts by a locked requester while the other requester waits.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- CLK  in  1  sole clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
REQ-003 SHALL provide, for each requester i in {0,1} (0 = host/PLB side, 1 = compute engine):
- reqi_valid  in  1  command present.
- reqi_ready  out  1  command accepted this cycle when high with valid.
- reqi_write  in  1  1 = write, 0 = read.
- reqi_lock  in  1  request to keep the grant for a burst.
- reqi_addr  in  14  word address.
- reqi_wdata  in  32  write data.
- reqi_be  in  4  byte enables for writes.
- rspi_valid  out  1  read data valid.
- rspi_data  out  32  read data.
REQ-004 SHALL provide the shared BRAM port:
- bramAddr  out  14  word address.
- bramDout  out  32  data to BRAM.
- bramWEN  out  4  byte write enables.
- bramEN  out  1  port enable.
- bramDin  in  32  BRAM read data, valid one cycle after an EN=1, WEN=0 cycle.

Function
REQ-005 SHALL accept at most one command per cycle; accept_i = reqi_valid & reqi_ready; reqi_ready SHALL be high only for the selected requester and may depend combinationally on both valid inputs.
REQ-006 SHALL arbitrate round-robin: a single `last` register records the most recently accepted requester; when both are valid and no lock is active, the requester other than `last` wins.
REQ-007 SHALL grant a lone valid requester in the same cycle (no idle bubble).
REQ-008 Lock: after requester i is accepted with reqi_lock=1, i SHALL keep priority while reqi_valid & reqi_lock stay high.
- The lock holds for up to MAX_BURST consecutive accepts.
- The lock then yields for one accept if the other requester is valid.
REQ-009 The burst counter SHALL clear when the grant changes, when the holder deasserts lock or valid, or when a forced yield occurs; the counter SHALL saturate and never wrap.
REQ-010 An accepted command SHALL be registered onto the BRAM port in the next cycle (T+1):
- bramEN=1, bramAddr=addr.
- bramDout=wdata.
- bramWEN=be for writes, 4'b0000 for reads.
REQ-011 A write accepted with be=4'b0000 SHALL be consumed, with bramEN=0 at T+1.
REQ-012 In cycles with no issue, the port SHALL idle:
- bramEN=0 and bramWEN=0.
- bramAddr and bramDout hold their previous values.
REQ-013 Reads SHALL carry a 1-bit requester tag through a two-stage valid pipeline.
- rspi_valid SHALL be high for exactly one cycle at T+2 for a read accepted at T.
- rspi_data SHALL equal bramDin in that cycle.
REQ-014 rspi_data SHALL be 0 whenever rspi_valid=0.
REQ-015 Writes SHALL produce no response.
REQ-016 Responses SHALL return in acceptance order; back-to-back reads from alternating requesters SHALL each complete with no loss.
REQ-017 Read data SHALL reflect writes accepted earlier: write at T then read at T+1 to the same address SHALL return the new data.
REQ-018 Sustained throughput SHALL be one access per cycle with both requesters continuously valid.

Reset
REQ-019 While RST_N=0, all of the following SHALL hold:
- All outputs are 0.
- last=1, so requester 0 wins the first tie.
- The burst counter is 0 and the lock is cleared.
- The response pipeline is empty.
REQ-020 Commands or reads in flight at reset assertion SHALL be discarded; no rspi_valid SHALL appear after reset release for pre-reset commands.
REQ-021 The first command SHALL be accepted in the first cycle after RST_N deasserts, with no extra start-up cycles.

Verification
REQ-022 The bench SHALL cover: after reset, both valid reads (addr 0x010 / 0x020, no lock) -> req0 accepted at T, req1 at T+1; bramEN at T+1, T+2 with addr 0x010, 0x020; rsp0_valid at T+2, rsp1_valid at T+3.
REQ-023 The bench SHALL cover: req0 write addr 0x005 data 0xDEADBEEF be=4'hF at T; req1 read addr 0x005 at T+1 -> bramWEN=4'hF at T+1; rsp1_data=0xDEADBEEF at T+3.
REQ-024 The bench SHALL cover: req1 holds lock+valid for 20 cycles with req0 valid, MAX_BURST=8 -> req1 gets 8 accepts, req0 gets 1, then req1 gets 8 more; the pattern repeats.
REQ-025 The bench SHALL cover: write with be=4'h0 -> reqi_ready=1, bramEN=0 at T+1, no rsp.
REQ-026 The bench SHALL cover: RST_N pulled low one cycle after a read is accepted -> all outputs 0 immediately; no rspi_valid after release.
REQ-027 The bench SHALL cover: a random 10k-cycle mix of both requesters against a BRAM model -> every read returns the model value; no grant to an invalid requester; no requester waits more than MAX_BURST+1 accepts.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of a single BRAM port.
// Accepted commands issue on the port one cycle later; read data returns tagged two cycles later.
module bram_port_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic        req0_lock,
    input  logic [13:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_be,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic        req1_lock,
    input  logic [13:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_be,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic [13:0] bramAddr,
    output logic [31:0] bramDout,
    output logic [3:0]  bramWEN,
    output logic        bramEN,
    input  logic [31:0] bramDin
);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic [1:0]    valid;
    logic [1:0]    lock;
    logic          last;
    logic          lock_active;
    logic          lock_owner;
    logic [CW-1:0] burst_cnt;
    logic          hold;
    logic          sel_valid;
    logic          sel;
    logic          accept;
    logic          cmd_write;
    logic          cmd_lock;
    logic [13:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_be;
    logic          rd_v1;
    logic          rd_tag1;
    logic          rd_v2;
    logic          rd_tag2;

    assign valid = {req1_valid, req0_valid};
    assign lock  = {req1_lock, req0_lock};

    // A saturated lock hands exactly one accept to a waiting peer, then the
    // normal round-robin lets the former holder start a fresh burst.
    always_comb begin
        sel_valid = 1'b0;
        sel       = 1'b0;
        hold      = lock_active && valid[lock_owner] && lock[lock_owner];
        if (hold) begin
            sel_valid = 1'b1;
            sel       = (burst_cnt == CNT_MAX && valid[~lock_owner]) ? ~lock_owner : lock_owner;
        end else if (valid == 2'b11) begin
            sel_valid = 1'b1;
            sel       = ~last;
        end else if (valid[0]) begin
            sel_valid = 1'b1;
            sel       = 1'b0;
        end else if (valid[1]) begin
            sel_valid = 1'b1;
            sel       = 1'b1;
        end
    end

    assign accept     = sel_valid && RST_N;
    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;

    assign cmd_write = sel ? req1_write : req0_write;
    assign cmd_lock  = sel ? req1_lock  : req0_lock;
    assign cmd_addr  = sel ? req1_addr  : req0_addr;
    assign cmd_wdata = sel ? req1_wdata : req0_wdata;
    assign cmd_be    = sel ? req1_be    : req0_be;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last        <= 1'b1;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            burst_cnt   <= '0;
        end else if (accept) begin
            last <= sel;
            if (!cmd_lock) begin
                lock_active <= 1'b0;
                burst_cnt   <= '0;
            end else if (hold && sel == lock_owner) begin
                if (burst_cnt != CNT_MAX) burst_cnt <= burst_cnt + CW'(1);
            end else begin
                lock_active <= 1'b1;
                lock_owner  <= sel;
                burst_cnt   <= CW'(1);
            end
        end else if (!hold) begin
            lock_active <= 1'b0;
            burst_cnt   <= '0;
        end
    end

    // A write with no byte enables is consumed without touching the port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bramEN   <= 1'b0;
            bramWEN  <= '0;
            bramAddr <= '0;
            bramDout <= '0;
            rd_v1    <= 1'b0;
            rd_tag1  <= 1'b0;
            rd_v2    <= 1'b0;
            rd_tag2  <= 1'b0;
        end else begin
            rd_v2   <= rd_v1;
            rd_tag2 <= rd_tag1;
            rd_v1   <= accept && !cmd_write;
            rd_tag1 <= sel;
            bramEN  <= 1'b0;
            bramWEN <= '0;
            if (accept && (!cmd_write || cmd_be != 4'h0)) begin
                bramEN   <= 1'b1;
                bramAddr <= cmd_addr;
                bramDout <= cmd_wdata;
                bramWEN  <= cmd_write ? cmd_be : 4'h0;
            end
        end
    end

    assign rsp0_valid = rd_v2 && !rd_tag2;
    assign rsp1_valid = rd_v2 && rd_tag2;
    assign rsp0_data  = rsp0_valid ? bramDin : '0;
    assign rsp1_data  = rsp1_valid ? bramDin : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed vector table, reset/lock sequences and a randomized mix for bram_port_arbiter.
module tb_bram_port_arbiter;
    localparam int unsigned MB = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req0_write, req0_lock, rsp0_valid;
    logic req1_valid, req1_ready, req1_write, req1_lock, rsp1_valid;
    logic [13:0] req0_addr, req1_addr, bramAddr;
    logic [31:0] req0_wdata, req1_wdata, rsp0_data, rsp1_data, bramDout, bramDin;
    logic [3:0]  req0_be, req1_be, bramWEN;
    logic        bramEN;

    always #5 clk = ~clk;

    bram_port_arbiter #(.MAX_BURST(MB)) dut (
        .CLK(clk), .RST_N(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_be(req0_be), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_be(req1_be), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .bramAddr(bramAddr), .bramDout(bramDout), .bramWEN(bramWEN),
        .bramEN(bramEN), .bramDin(bramDin)
    );

    // BRAM model: synchronous, byte-writable, one-cycle read latency.
    logic [31:0] mem [0:16383];
    bit init_done;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int a = 0; a < 16384; a++) mem[a] <= 32'h5A5A0000 | 32'(a);
            init_done <= 1'b1;
            bramDin   <= '0;
        end else if (bramEN) begin
            for (int b = 0; b < 4; b++)
                if (bramWEN[b]) mem[bramAddr][8*b +: 8] <= bramDout[8*b +: 8];
            bramDin <= mem[bramAddr];
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [118:0] all_outs;
    assign all_outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
                       bramAddr, bramDout, bramWEN, bramEN};

    typedef struct {
        logic [3:0]  vw;      // {v0, v1, w0, w1}
        logic [13:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  be0, be1;
        logic [3:0]  obs;     // {rdy0, rdy1, rsp0, rsp1} during the cycle
        logic [31:0] rdata;
        logic        en;
        logic [3:0]  wen;
        logic [13:0] addr;
        logic [31:0] dout;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    task automatic drive(input logic [3:0] vw, input logic [13:0] a0, input logic [13:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] be0, input logic [3:0] be1,
                         input logic l0, input logic l1);
        {req0_valid, req1_valid, req0_write, req1_write} = vw;
        req0_addr = a0; req1_addr = a1; req0_wdata = d0; req1_wdata = d1;
        req0_be = be0; req1_be = be1; req0_lock = l0; req1_lock = l1;
    endtask

    typedef struct { logic tag; logic [31:0] data; } exp_t;
    exp_t q[$];
    logic [31:0] shadow [0:31];
    logic        pend [2];
    logic        cw [2];
    logic        lk [2];
    logic [13:0] ca [2];
    logic [31:0] cd [2];
    logic [3:0]  cbe [2];
    int          waitc [2];

    task automatic rand_step(input bit gen);
        logic [1:0] rdy, v;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (gen && !pend[i] && $urandom_range(0, 3) != 0) begin
                pend[i] = 1'b1;
                cw[i]   = 1'($urandom_range(0, 1));
                ca[i]   = 14'($urandom_range(0, 31));
                cd[i]   = $urandom;
                cbe[i]  = 4'($urandom_range(0, 15));
            end
            if (!gen) pend[i] = 1'b0;
            if ($urandom_range(0, 15) == 0) lk[i] = ~lk[i];
        end
        drive({pend[0], pend[1], cw[0], cw[1]}, ca[0], ca[1], cd[0], cd[1], cbe[0], cbe[1], lk[0], lk[1]);
        #1;
        rdy = {req1_ready, req0_ready};
        v   = {req1_valid, req0_valid};
        check("rand_grant", {rdy[0] & rdy[1], rdy[0] & ~v[0], rdy[1] & ~v[1]}, 3'b000);
        check("rand_idle_data", {!rsp0_valid && rsp0_data != 0, !rsp1_valid && rsp1_data != 0}, 2'b00);
        if (rsp0_valid || rsp1_valid) begin
            if (q.size() == 0 || (rsp0_valid && rsp1_valid)) begin
                check("rand_rsp_unexpected", {rsp0_valid, rsp1_valid, 32'(q.size())}, {2'b00, 32'd0});
            end else begin
                e = q.pop_front();
                check("rand_rsp", {rsp1_valid, rsp0_data | rsp1_data}, {e.tag, e.data});
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rdy[i] && v[i]) begin
                if (cw[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (cbe[i][b]) shadow[ca[i][4:0]][8*b +: 8] = cd[i][8*b +: 8];
                end else begin
                    e.tag = 1'(i); e.data = shadow[ca[i][4:0]];
                    q.push_back(e);
                end
                pend[i]  = 1'b0;
                waitc[i] = 0;
                if (pend[1-i]) waitc[1-i]++;
            end
        end
        check("rand_wait", {waitc[0] > int'(MB) + 1, waitc[1] > int'(MB) + 1}, 2'b00);
    endtask

    initial begin
        tbl[0]  = '{4'b1100, 14'h010, 14'h020, 32'h0, 32'h0, 4'h0, 4'h0, 4'b1000, 32'h0, 1'b1, 4'h0, 14'h010, 32'h0};
        tbl[1]  = '{4'b0100, 14'h000, 14'h020, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0100, 32'h0, 1'b1, 4'h0, 14'h020, 32'h0};
        tbl[2]  = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0010, 32'h5A5A0010, 1'b0, 4'h0, 14'h020, 32'h0};
        tbl[3]  = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 32'h5A5A0020, 1'b0, 4'h0, 14'h020, 32'h0};
        tbl[4]  = '{4'b1010, 14'h005, 14'h000, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 4'b1000, 32'h0, 1'b1, 4'hF, 14'h005, 32'hDEADBEEF};
        tbl[5]  = '{4'b0100, 14'h000, 14'h005, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0100, 32'h0, 1'b1, 4'h0, 14'h005, 32'h0};
        tbl[6]  = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0000, 32'h0, 1'b0, 4'h0, 14'h005, 32'h0};
        tbl[7]  = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 32'hDEADBEEF, 1'b0, 4'h0, 14'h005, 32'h0};
        tbl[8]  = '{4'b0101, 14'h000, 14'h007, 32'h0, 32'h12345678, 4'h0, 4'h0, 4'b0100, 32'h0, 1'b0, 4'h0, 14'h005, 32'h0};
        tbl[9]  = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0000, 32'h0, 1'b0, 4'h0, 14'h005, 32'h0};
        tbl[10] = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0000, 32'h0, 1'b0, 4'h0, 14'h005, 32'h0};
        tbl[11] = '{4'b1100, 14'h030, 14'h040, 32'h0, 32'h0, 4'h0, 4'h0, 4'b1000, 32'h0, 1'b1, 4'h0, 14'h030, 32'h0};
        tbl[12] = '{4'b1100, 14'h030, 14'h040, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0100, 32'h0, 1'b1, 4'h0, 14'h040, 32'h0};
        tbl[13] = '{4'b1100, 14'h030, 14'h040, 32'h0, 32'h0, 4'h0, 4'h0, 4'b1010, 32'h5A5A0030, 1'b1, 4'h0, 14'h030, 32'h0};
        tbl[14] = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 32'h5A5A0040, 1'b0, 4'h0, 14'h030, 32'h0};
        tbl[15] = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0010, 32'h5A5A0030, 1'b0, 4'h0, 14'h030, 32'h0};
        tbl[16] = '{4'b0100, 14'h000, 14'h011, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0100, 32'h0, 1'b1, 4'h0, 14'h011, 32'h0};
        tbl[17] = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0000, 32'h0, 1'b0, 4'h0, 14'h011, 32'h0};
        tbl[18] = '{4'b0000, 14'h000, 14'h000, 32'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 32'h5A5A0011, 1'b0, 4'h0, 14'h011, 32'h0};

        rst_n = 1'b0;
        drive(4'b0000, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        drive(4'b1100, 14'h001, 14'h002, '0, '0, '0, '0, 1'b0, 1'b0);
        #1 check("reset_outputs", all_outs, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].vw, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].be0, tbl[i].be1, 1'b0, 1'b0);
            #1 check($sformatf("vec%0d_cycle", i),
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data | rsp1_data},
                     {tbl[i].obs, tbl[i].rdata});
            @(posedge clk);
            #1 check($sformatf("vec%0d_port", i), {bramEN, bramWEN, bramAddr, bramDout},
                     {tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].dout});
            @(negedge clk);
        end

        // Reset one cycle after a read is accepted: everything must vanish.
        drive(4'b1000, 14'h020, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        #1 check("pre_reset_accept", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        drive(4'b1100, 14'h021, 14'h022, '0, '0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 check("reset_midflight_outputs", all_outs, '0);
        repeat (2) @(negedge clk);
        drive(4'b0000, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("post_reset_no_rsp%0d", k), {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}, '0);
            @(negedge clk);
        end

        // req1 locked and req0 waiting: 1 tie-break to req0, then 8 to req1, 1 to req0, ...
        drive(4'b1100, 14'h100, 14'h200, '0, '0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            logic g;
            g = (k == 0) ? 1'b0 : (((k - 1) % 9) != 8);
            #1 check($sformatf("lock_grant%0d", k), {req0_ready, req1_ready}, {~g, g});
            @(negedge clk);
        end
        drive(4'b0000, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        for (int a = 0; a < 32; a++) shadow[a] = mem[a];
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; cw[i] = 1'b0; lk[i] = 1'b0; ca[i] = '0; cd[i] = '0; cbe[i] = '0; waitc[i] = 0;
        end
        for (int c = 0; c < 10000; c++) rand_step(1'b1);
        for (int c = 0; c < 4; c++) rand_step(1'b0);
        check("rand_queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
